pwr_seq_ctrl: RTL and testbench
===============================

# pwr_seq_ctrl

Power-up sequencing controller for the sync board front end. It drives the converter power-down line and the datapath reset, and waits for a stable PLL lock before releasing reset. It bounds the lock wait with a timeout and retries, and re-sequences on lock loss or software request. It replaces a fixed power-on counter with a closed-loop state machine whose status software can read.

## Interface
Parameters:
- PWRDWN_CYC, 1200000: cycles `pwrdwn` is held high per attempt (≥1).
- LOCK_STABLE_CYC, 10000: consecutive synchronized-lock cycles required (≥1).
- LOCK_TIMEOUT, 20000000: maximum cycles spent in WAIT_LOCK per attempt (≥ LOCK_STABLE_CYC).
- RST_HOLD_CYC, 10000: cycles `reset_init` stays high after lock is accepted (≥1).
- MAX_RETRY, 3: retries allowed before FAULT (0..15).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock, no other clocks.
- pll_lock  in  1  asynchronous PLL lock indicator; passes through an internal 2-flop synchronizer.
- reseq_req  in  1  single-cycle pulse that restarts the sequence from PWRDWN.
- pwrdwn  out  1  converter power-down, active-high.
- reset_init  out  1  datapath reset, active-high.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- lock_lost  out  1  sticky; set on lock loss in RUN, cleared by `reset` or `reseq_req`.
- state  out  3  PWRDWN=0, WAIT_LOCK=1, RST_HOLD=2, RUN=3, FAULT=4.
- retry_cnt  out  4  timeouts in the current sequence.

## Operation
- Reset values: state=PWRDWN, pwrdwn=1, reset_init=1, ready=0, fault=0, lock_lost=0, retry_cnt=0, cycle counter=0, lock counter=0, synchronizer=0.
- Outputs are registered and updated on the same edge as `state`. They always match the current state, with no extra lag:
  - PWRDWN: pwrdwn=1, reset_init=1.
  - WAIT_LOCK: pwrdwn=0, reset_init=1.
  - RST_HOLD: pwrdwn=0, reset_init=1.
  - RUN: pwrdwn=0, reset_init=0, ready=1.
  - FAULT: pwrdwn=1, reset_init=1, fault=1.
- A 32-bit cycle counter clears on every state entry and increments each cycle in PWRDWN, WAIT_LOCK and RST_HOLD. It never wraps within legal parameter ranges.
- PWRDWN → WAIT_LOCK when the cycle counter reaches PWRDWN_CYC-1.
- WAIT_LOCK:
  - A 32-bit lock counter increments while synced lock=1 and clears to 0 whenever synced lock=0.
  - → RST_HOLD when synced lock=1 and lock counter = LOCK_STABLE_CYC-1.
  - Else → PWRDWN with retry_cnt+1 when the cycle counter reaches LOCK_TIMEOUT-1 and retry_cnt < MAX_RETRY.
  - Else → FAULT when the timeout occurs and retry_cnt = MAX_RETRY.
  - Lock acceptance beats timeout when both occur in the same cycle.
- RST_HOLD:
  - → RUN when the cycle counter reaches RST_HOLD_CYC-1.
  - → WAIT_LOCK if synced lock=0, with both counters cleared.
- RUN:
  - retry_cnt clears on entry.
  - Synced lock=0 → WAIT_LOCK and lock_lost=1. No power-down occurs.
- FAULT is terminal; only `reseq_req` or `reset` exits it.
- Priority: `reset` > `reseq_req` > normal transitions. `reseq_req` in any state → PWRDWN next cycle and clears retry_cnt, lock_lost and both counters.

## Timing
- Cycle 0 is the first rising edge with `reset`=0; state is PWRDWN at cycle 0.
- pll_lock has 2 cycles of synchronizer latency before it is seen by the FSM.
- Lock loss in RUN: reset_init rises and ready falls 3 edges after pll_lock falls (2 synchronizer + 1 FSM).
- `reseq_req` sampled high at edge N: state=PWRDWN and pwrdwn=1 visible after edge N.
- `reset` asserted mid-sequence: reset values apply after the next edge, whatever the current state.

## Test plan
The bench overrides parameters to PWRDWN_CYC=8, LOCK_STABLE_CYC=4, LOCK_TIMEOUT=20, RST_HOLD_CYC=6, MAX_RETRY=2.
- Clean bring-up: pll_lock=1 from reset → pwrdwn=1 on cycles 0-7, WAIT_LOCK cycles 8-11, RST_HOLD 12-17; at cycle 18 reset_init=0, ready=1, retry_cnt=0.
- No lock: pll_lock=0 → WAIT_LOCK timeouts at cycles 27, 55 and 83, with retry_cnt=1 at cycle 28 and retry_cnt=2 at cycle 56. At cycle 84 state=4, fault=1, pwrdwn=1.
- Lock glitch: pll_lock drops for 1 cycle when lock counter=2 → counter restarts; RST_HOLD is entered 4 synced-high cycles after the glitch, not before.
- Loss in RUN: pll_lock falls at edge E while in RUN → reset_init=1, ready=0, lock_lost=1 at E+3 with pwrdwn=0. Relock leads to RUN again after 4+6 cycles; lock_lost stays 1.
- Recovery from FAULT: pulse reseq_req in FAULT → next cycle state=0, fault=0, retry_cnt=0, lock_lost=0. A reseq_req in the same cycle as a timeout also yields PWRDWN with retry_cnt=0.
- Reset mid-RST_HOLD: assert reset at cycle 14 of clean bring-up → after next edge state=0, pwrdwn=1, reset_init=1, ready=0; after release the sequence repeats with the clean bring-up timing.

Source files
------------

// File: rtl/pwr_seq_ctrl.sv
// Power-up sequencing controller: holds the converters in power-down, qualifies
// PLL lock with a timeout/retry loop, then releases the datapath reset.
module pwr_seq_ctrl #(
    parameter int unsigned PWRDWN_CYC      = 1200000,
    parameter int unsigned LOCK_STABLE_CYC = 10000,
    parameter int unsigned LOCK_TIMEOUT    = 20000000,
    parameter int unsigned RST_HOLD_CYC    = 10000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       reseq_req,
    output logic       pwrdwn,
    output logic       reset_init,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);
    typedef enum logic [2:0] {
        ST_PWRDWN    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [31:0] PWRDWN_LAST  = 32'(PWRDWN_CYC - 32'd1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYC - 32'd1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 32'd1);
    localparam logic [31:0] HOLD_LAST    = 32'(RST_HOLD_CYC - 32'd1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t      state_r, state_s;
    logic        lock_meta_r, lock_sync_r;
    logic [31:0] cyc_cnt_r, cyc_cnt_s;
    logic [31:0] lock_cnt_r, lock_cnt_s;
    logic [3:0]  retry_cnt_r, retry_cnt_s;
    logic        lock_lost_r, lock_lost_s;
    logic        pwrdwn_r, reset_init_r, ready_r, fault_r;
    logic        pwrdwn_s, reset_init_s, ready_s, fault_s;

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, counter and status logic; a resequence request overrides all.
    always_comb begin
        state_s     = state_r;
        lock_cnt_s  = 32'd0;
        retry_cnt_s = retry_cnt_r;
        lock_lost_s = lock_lost_r;
        if (reseq_req) begin
            state_s     = ST_PWRDWN;
            retry_cnt_s = 4'd0;
            lock_lost_s = 1'b0;
        end else begin
            case (state_r)
                ST_PWRDWN: begin
                    if (cyc_cnt_r == PWRDWN_LAST) state_s = ST_WAIT_LOCK;
                    else                          state_s = ST_PWRDWN;
                end
                ST_WAIT_LOCK: begin
                    // Lock acceptance is checked first so it wins a same-cycle timeout.
                    if (lock_sync_r && (lock_cnt_r == STABLE_LAST)) begin
                        state_s = ST_RST_HOLD;
                    end else if (cyc_cnt_r == TIMEOUT_LAST) begin
                        if (retry_cnt_r < RETRY_LIMIT) begin
                            state_s     = ST_PWRDWN;
                            retry_cnt_s = retry_cnt_r + 4'd1;
                        end else begin
                            state_s = ST_FAULT;
                        end
                    end else if (lock_sync_r) begin
                        lock_cnt_s = lock_cnt_r + 32'd1;
                    end else begin
                        lock_cnt_s = 32'd0;
                    end
                end
                ST_RST_HOLD: begin
                    if (!lock_sync_r) begin
                        state_s = ST_WAIT_LOCK;
                    end else if (cyc_cnt_r == HOLD_LAST) begin
                        state_s     = ST_RUN;
                        retry_cnt_s = 4'd0;
                    end else begin
                        state_s = ST_RST_HOLD;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_s     = ST_WAIT_LOCK;
                        lock_lost_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAULT: state_s = ST_FAULT;
                default:  state_s = ST_PWRDWN;
            endcase
        end

        if ((state_s != state_r) || reseq_req) begin
            cyc_cnt_s = 32'd0;
        end else if ((state_r == ST_PWRDWN) || (state_r == ST_WAIT_LOCK) ||
                     (state_r == ST_RST_HOLD)) begin
            cyc_cnt_s = cyc_cnt_r + 32'd1;
        end else begin
            cyc_cnt_s = cyc_cnt_r;
        end
    end

    // Output decode from the next state so registered outputs track state with no lag.
    always_comb begin
        pwrdwn_s     = 1'b1;
        reset_init_s = 1'b1;
        ready_s      = 1'b0;
        fault_s      = 1'b0;
        case (state_s)
            ST_PWRDWN:    pwrdwn_s = 1'b1;
            ST_WAIT_LOCK: pwrdwn_s = 1'b0;
            ST_RST_HOLD:  pwrdwn_s = 1'b0;
            ST_RUN: begin
                pwrdwn_s     = 1'b0;
                reset_init_s = 1'b0;
                ready_s      = 1'b1;
            end
            ST_FAULT:     fault_s  = 1'b1;
            default:      pwrdwn_s = 1'b1;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_PWRDWN;
            cyc_cnt_r    <= 32'd0;
            lock_cnt_r   <= 32'd0;
            retry_cnt_r  <= 4'd0;
            lock_lost_r  <= 1'b0;
            pwrdwn_r     <= 1'b1;
            reset_init_r <= 1'b1;
            ready_r      <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            cyc_cnt_r    <= cyc_cnt_s;
            lock_cnt_r   <= lock_cnt_s;
            retry_cnt_r  <= retry_cnt_s;
            lock_lost_r  <= lock_lost_s;
            pwrdwn_r     <= pwrdwn_s;
            reset_init_r <= reset_init_s;
            ready_r      <= ready_s;
            fault_r      <= fault_s;
        end
    end

    assign state      = state_r;
    assign retry_cnt  = retry_cnt_r;
    assign lock_lost  = lock_lost_r;
    assign pwrdwn     = pwrdwn_r;
    assign reset_init = reset_init_r;
    assign ready      = ready_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed scoreboard bench for pwr_seq_ctrl: expected output snapshots are
// queued per cycle and compared at the falling edge of that cycle.
module tb_pwr_seq_ctrl;
    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       reseq_req;
    logic       pwrdwn, reset_init, ready, fault, lock_lost;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pwr_seq_ctrl #(
        .PWRDWN_CYC     (8),
        .LOCK_STABLE_CYC(4),
        .LOCK_TIMEOUT   (20),
        .RST_HOLD_CYC   (6),
        .MAX_RETRY      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .reseq_req (reseq_req),
        .pwrdwn    (pwrdwn),
        .reset_init(reset_init),
        .ready     (ready),
        .fault     (fault),
        .lock_lost (lock_lost),
        .state     (state),
        .retry_cnt (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value k means the DUT outputs currently show cycle k.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [11:0] ev(input logic [2:0] st, input logic pd, input logic ri,
                                       input logic rdy, input logic flt, input logic ll,
                                       input logic [3:0] rc);
        return {st, pd, ri, rdy, flt, ll, rc};
    endfunction

    function automatic logic [11:0] v_pd(input logic ll, input logic [3:0] rc);
        return ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, ll, rc);
    endfunction
    function automatic logic [11:0] v_wait(input logic ll, input logic [3:0] rc);
        return ev(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, ll, rc);
    endfunction
    function automatic logic [11:0] v_hold(input logic ll, input logic [3:0] rc);
        return ev(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, ll, rc);
    endfunction
    function automatic logic [11:0] v_run(input logic ll);
        return ev(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, ll, 4'd0);
    endfunction
    function automatic logic [11:0] v_fault(input logic [3:0] rc);
        return ev(3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rc);
    endfunction

    task automatic push(input int c, input string tag, input logic [11:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // One clock: compare anything due at the falling edge, then step past the next rising edge.
    task automatic tick();
        logic [11:0] obs;
        exp_t        e;
        @(negedge clk);
        while ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
            e   = sb.pop_front();
            obs = {state, pwrdwn, reset_init, ready, fault, lock_lost, retry_cnt};
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: cycle %0d observed %h expected %h", e.tag, cyc, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while ((cyc != n) && (guard < 400)) begin
            tick();
            guard++;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() > 0) && (guard < 400)) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL drain_timeout: %0d expectations left, observed none expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_dut(input logic lock);
        reset     = 1'b1;
        reseq_req = 1'b0;
        pll_lock  = lock;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        pll_lock  = 1'b0;
        reseq_req = 1'b0;

        // Clean bring-up, lock loss in RUN, relock, then resequence clears lock_lost.
        reset_dut(1'b1);
        push(0,  "rst_vals",     v_pd(1'b0, 4'd0));
        push(7,  "pd_last",      v_pd(1'b0, 4'd0));
        push(8,  "wait_first",   v_wait(1'b0, 4'd0));
        push(11, "wait_last",    v_wait(1'b0, 4'd0));
        push(12, "hold_first",   v_hold(1'b0, 4'd0));
        push(17, "hold_last",    v_hold(1'b0, 4'd0));
        push(18, "run_first",    v_run(1'b0));
        push(22, "loss_pre",     v_run(1'b0));
        push(23, "loss_e3",      v_wait(1'b1, 4'd0));
        push(28, "relock_wait",  v_wait(1'b1, 4'd0));
        push(29, "relock_hold",  v_hold(1'b1, 4'd0));
        push(35, "relock_run",   v_run(1'b1));
        push(40, "sticky_ll",    v_run(1'b1));
        push(41, "reseq_ll_clr", v_pd(1'b0, 4'd0));
        push(59, "reseq_run",    v_run(1'b0));
        goto(20); pll_lock  = 1'b0;
        goto(23); pll_lock  = 1'b1;
        goto(40); reseq_req = 1'b1;
        goto(41); reseq_req = 1'b0;
        drain();

        // No lock: timeouts with retries, FAULT, recovery, reseq beating a timeout.
        reset_dut(1'b0);
        push(8,   "nl_wait",      v_wait(1'b0, 4'd0));
        push(27,  "nl_to1",       v_wait(1'b0, 4'd0));
        push(28,  "nl_retry1",    v_pd(1'b0, 4'd1));
        push(55,  "nl_to2",       v_wait(1'b0, 4'd1));
        push(56,  "nl_retry2",    v_pd(1'b0, 4'd2));
        push(83,  "nl_to3",       v_wait(1'b0, 4'd2));
        push(84,  "fault_entry",  v_fault(4'd2));
        push(90,  "fault_hold",   v_fault(4'd2));
        push(91,  "fault_reseq",  v_pd(1'b0, 4'd0));
        push(99,  "rec_wait",     v_wait(1'b0, 4'd0));
        push(119, "rec_retry1",   v_pd(1'b0, 4'd1));
        push(146, "rec_to",       v_wait(1'b0, 4'd1));
        push(147, "reseq_vs_to",  v_pd(1'b0, 4'd0));
        goto(90);  reseq_req = 1'b1;
        goto(91);  reseq_req = 1'b0;
        goto(146); reseq_req = 1'b1;
        goto(147); reseq_req = 1'b0;
        drain();

        // One-cycle lock glitch while the lock counter is at 2 restarts qualification.
        reset_dut(1'b1);
        push(10, "gl_cnt2",      v_wait(1'b0, 4'd0));
        push(11, "gl_no_early",  v_wait(1'b0, 4'd0));
        push(14, "gl_still",     v_wait(1'b0, 4'd0));
        push(15, "gl_hold",      v_hold(1'b0, 4'd0));
        push(21, "gl_run",       v_run(1'b0));
        goto(8); pll_lock = 1'b0;
        goto(9); pll_lock = 1'b1;
        drain();

        // Reset asserted during RST_HOLD, then a repeat clean bring-up.
        reset_dut(1'b1);
        push(12, "mr_hold", v_hold(1'b0, 4'd0));
        push(13, "mr_hold2", v_hold(1'b0, 4'd0));
        drain();
        reset = 1'b1;
        push(0, "mr_reset", v_pd(1'b0, 4'd0));
        drain();
        reset = 1'b0;
        push(0,  "rb_rst",  v_pd(1'b0, 4'd0));
        push(7,  "rb_pd",   v_pd(1'b0, 4'd0));
        push(8,  "rb_wait", v_wait(1'b0, 4'd0));
        push(12, "rb_hold", v_hold(1'b0, 4'd0));
        push(18, "rb_run",  v_run(1'b0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
